// File: rtl/xsync_bus_rx.sv
// ---------------------------------------------------------------------------
// xsync_bus_rx
// Receive side of a two-phase (toggle) request/acknowledge bus crossing.
// Detects each toggle of the already-synchronized request, waits SETTLE
// cycles for the sender's quasi-static bus to settle, captures it, and
// offers it on a valid/ready interface. Completion is returned to the
// sender as a toggle on ack_tgl, driven straight from a flop so it can be
// synchronized in the sender's domain.
//
// Build option:
//   XSYNC_BUS_RX_BUF_EN undefined : single holding register; ack is returned
//                                   when the downstream accepts the word.
//   XSYNC_BUS_RX_BUF_EN defined   : 2-entry FIFO; ack is returned one cycle
//                                   after capture while a slot stays free,
//                                   otherwise after the pop that frees one.
// ---------------------------------------------------------------------------
module xsync_bus_rx #(
  parameter int DW     = 8,
  parameter int SETTLE = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req_sync,
  input  logic [DW-1:0] bus_d,
  output logic          ack_tgl,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  input  logic          o_ready,
  output logic          err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } state_t;

  localparam logic [1:0] SETTLE_CNT = 2'(SETTLE);

  logic       req_q;
  logic       req_edge;
  state_t     state;
  logic [1:0] cnt;

  // Previous request level, so every toggle shows up as a one-cycle edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_q <= 1'b0;
    end else begin
      // NOTE: state is updated with <= so every flop samples pre-edge values.
      req_q <= req_sync;
    end
  end

  assign req_edge = req_sync ^ req_q;

`ifndef XSYNC_BUS_RX_BUF_EN

  // Request FSM with single holding register; all outputs are flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      cnt     <= 2'd0;
      o_valid <= 1'b0;
      o_data  <= '0;
      ack_tgl <= 1'b0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_edge) begin
            cnt <= SETTLE_CNT;
            if (SETTLE == 0) begin
              // No settle time: the bus is taken at the detecting edge.
              o_data  <= bus_d;
              o_valid <= 1'b1;
              state   <= ST_HOLD;
            end else begin
              state <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          // A second toggle here is a sender error; it is dropped.
          if (req_edge) err <= 1'b1;
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) begin
            o_data  <= bus_d;
            o_valid <= 1'b1;
            state   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (req_edge) err <= 1'b1;
          if (o_valid && o_ready) begin
            ack_tgl <= ~ack_tgl;
            o_valid <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`else

  logic [DW-1:0] fifo_mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic [1:0]    count_nxt;
  logic          ack_due;
  logic          ack_hold;
  logic          push;
  logic          pop;
  logic          new_due;

  // Capture decode: a capture is a FIFO push.
  always_comb begin
    // NOTE: default first so no path leaves push unassigned (no latch).
    push = 1'b0;
    if (state == ST_IDLE && req_edge && !ack_hold && (SETTLE == 0)) push = 1'b1;
    if (state == ST_SETTLE && cnt == 2'd1)                         push = 1'b1;
  end

  assign pop       = o_valid & o_ready;
  assign count_nxt = count + {1'b0, push} - {1'b0, pop};
  // Ack goes out next cycle if a slot remains, or once a held ack is freed.
  assign new_due   = (push && count_nxt <= 2'd1) || (pop && ack_hold);

  // Request FSM: waits out the settle time, refuses edges while ack is held.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      cnt   <= 2'd0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_edge) begin
            if (ack_hold) begin
              err <= 1'b1;
            end else if (SETTLE != 0) begin
              cnt   <= SETTLE_CNT;
              state <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (req_edge) err <= 1'b1;
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Two-entry FIFO; cannot overflow because a full FIFO always holds the ack.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: storage is reset here only because o_data must read 0 in reset.
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= bus_d;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count_nxt;
    end
  end

  // Acknowledge generation: immediate-next-cycle or deferred until a pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack_tgl  <= 1'b0;
      ack_due  <= 1'b0;
      ack_hold <= 1'b0;
    end else begin
      ack_tgl <= ack_tgl ^ ack_due;
      ack_due <= new_due;
      if (push && count_nxt == 2'd2) begin
        ack_hold <= 1'b1;
      end else if (pop && ack_hold) begin
        ack_hold <= 1'b0;
      end
    end
  end

  assign o_valid = (count != 2'd0);
  assign o_data  = fifo_mem[rd_ptr];

`endif

endmodule

// File: tb/tb_xsync_bus_rx.sv
// ---------------------------------------------------------------------------
// tb_xsync_bus_rx
// Self-checking bench. The main instance uses SETTLE=1; four more instances
// (SETTLE 0..3) share a separate request/bus pair for the settle sweep.
// Expected values come from the timing rules (cycle offsets from the request
// edge), a parity counter for ack and a queue of words sent.
// ---------------------------------------------------------------------------
module tb_xsync_bus_rx;

  localparam int DW = 8;
  localparam int S  = 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req_sync = 1'b0;
  logic [DW-1:0] bus_d = '0;
  logic          o_ready = 1'b0;
  logic          ack_tgl;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          err;

  logic          sw_req = 1'b0;
  logic [DW-1:0] sw_bus = '0;
  logic          sw_ready = 1'b1;
  logic [3:0]    sw_ack;
  logic [3:0]    sw_valid;
  logic [3:0]    sw_err;
  logic [DW-1:0] sw_data [4];

  int checks = 0;
  int errors = 0;
  logic exp_ack = 1'b0;
  logic sw_par = 1'b0;
  logic [DW-1:0] sent_q [$];

  always #5 clk = ~clk;

  xsync_bus_rx #(.DW(DW), .SETTLE(S)) u_dut (
    .clk      (clk),
    .rstn     (rstn),
    .req_sync (req_sync),
    .bus_d    (bus_d),
    .ack_tgl  (ack_tgl),
    .o_valid  (o_valid),
    .o_data   (o_data),
    .o_ready  (o_ready),
    .err      (err)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    xsync_bus_rx #(.DW(DW), .SETTLE(g)) u_sw (
      .clk      (clk),
      .rstn     (rstn),
      .req_sync (sw_req),
      .bus_d    (sw_bus),
      .ack_tgl  (sw_ack[g]),
      .o_valid  (sw_valid[g]),
      .o_data   (sw_data[g]),
      .o_ready  (sw_ready),
      .err      (sw_err[g])
    );
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge (the start of a new cycle).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete request from the sender, toggled in the current cycle.
  task automatic run_xfer(input logic [DW-1:0] d, input int stall, input string tag);
    logic [DW-1:0] exp_d;
    req_sync = ~req_sync;
    bus_d    = d;
    o_ready  = 1'b0;
    sent_q.push_back(d);
    for (int k = 0; k <= S; k++) begin
      checks++;
      if ({o_valid, err, ack_tgl} !== {1'b0, 1'b0, exp_ack}) begin
        errors++;
        $display("FAIL %s settle k=%0d: valid/err/ack=%b%b%b expected 00%b",
                 tag, k, o_valid, err, ack_tgl, exp_ack);
      end
      step();
    end
    exp_d = sent_q.pop_front();
    for (int k = 0; k < stall; k++) begin
      checks++;
      if ({o_valid, o_data, ack_tgl} !== {1'b1, exp_d, exp_ack}) begin
        errors++;
        $display("FAIL %s stall k=%0d: valid=%b data=%h ack=%b expected 1 %h %b",
                 tag, k, o_valid, o_data, ack_tgl, exp_d, exp_ack);
      end
      step();
    end
    o_ready = 1'b1;
    checks++;
    if ({o_valid, o_data, ack_tgl, err} !== {1'b1, exp_d, exp_ack, 1'b0}) begin
      errors++;
      $display("FAIL %s accept: valid=%b data=%h ack=%b err=%b expected 1 %h %b 0",
               tag, o_valid, o_data, ack_tgl, err, exp_d, exp_ack);
    end
    step();
    o_ready = 1'b0;
    exp_ack = ~exp_ack;
    checks++;
    if ({o_valid, ack_tgl} !== {1'b0, exp_ack}) begin
      errors++;
      $display("FAIL %s ack: valid=%b ack=%b expected 0 %b", tag, o_valid, ack_tgl, exp_ack);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_sync = 1'b0; o_ready = 1'b0; bus_d = '0;
    sw_req = 1'b0; sw_bus = '0; sw_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ack_tgl, o_valid, o_data, err} !== 11'd0) begin
      errors++;
      $display("FAIL reset_init: ack/valid/data/err=%b %b %h %b expected all 0",
               ack_tgl, o_valid, o_data, err);
    end
    #2 rstn = 1'b1;
    step();
    // Bring the DUT into HOLD with 0xA5, stalled.
    req_sync = ~req_sync; bus_d = 8'hA5; o_ready = 1'b0;
    repeat (S + 1) step();
    checks++;
    if ({o_valid, o_data} !== {1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL reset_hold_setup: valid=%b data=%h expected 1 a5", o_valid, o_data);
    end
    #2 rstn = 1'b0; req_sync = 1'b0;
    #1;
    checks++;
    if ({ack_tgl, o_valid, o_data, err} !== 11'd0) begin
      errors++;
      $display("FAIL reset_async: ack/valid/data/err=%b %b %h %b expected all 0",
               ack_tgl, o_valid, o_data, err);
    end
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    exp_ack = 1'b0;
    sent_q.delete();
    step();
    checks++;
    if ({ack_tgl, o_valid, err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release: ack/valid/err=%b%b%b expected 000", ack_tgl, o_valid, err);
    end
    // A fresh request is accepted straight away, proving the FSM is idle.
    run_xfer(8'($urandom), 0, "reset_idle");
  endtask

`ifndef XSYNC_BUS_RX_BUF_EN
  task automatic test_single();
    step();
    run_xfer(8'h3C, 0, "single");
  endtask

  task automatic test_stall();
    step();
    run_xfer(8'h3C, 20, "stall");
  endtask

  task automatic test_violation();
    logic [DW-1:0] d;
    // Extra toggle while holding a word.
    step();
    d = 8'($urandom);
    req_sync = ~req_sync; bus_d = d; o_ready = 1'b0;
    repeat (S + 1) step();
    step();
    req_sync = ~req_sync;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL viol_hold_pre: err=%b expected 0", err);
    end
    step();
    checks++;
    if ({err, o_valid, o_data, ack_tgl} !== {1'b1, 1'b1, d, exp_ack}) begin
      errors++;
      $display("FAIL viol_hold_err: err/valid/data/ack=%b %b %h %b expected 1 1 %h %b",
               err, o_valid, o_data, ack_tgl, d, exp_ack);
    end
    step();
    checks++;
    if ({err, o_data} !== {1'b0, d}) begin
      errors++;
      $display("FAIL viol_hold_pulse: err=%b data=%h expected 0 %h", err, o_data, d);
    end
    o_ready = 1'b1;
    step();
    o_ready = 1'b0;
    exp_ack = ~exp_ack;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({ack_tgl, o_valid, err} !== {exp_ack, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL viol_hold_once k=%0d: ack/valid/err=%b%b%b expected %b00",
                 k, ack_tgl, o_valid, err, exp_ack);
      end
      step();
    end
    // Extra toggle during the settle cycle.
    d = 8'($urandom);
    req_sync = ~req_sync; bus_d = d;
    step();
    req_sync = ~req_sync;
    step();
    checks++;
    if ({err, o_valid, o_data} !== {1'b1, 1'b1, d}) begin
      errors++;
      $display("FAIL viol_settle: err/valid/data=%b %b %h expected 1 1 %h",
               err, o_valid, o_data, d);
    end
    o_ready = 1'b1;
    step();
    o_ready = 1'b0;
    exp_ack = ~exp_ack;
    checks++;
    if ({err, o_valid, ack_tgl} !== {1'b0, 1'b0, exp_ack}) begin
      errors++;
      $display("FAIL viol_settle_ack: err/valid/ack=%b%b%b expected 00%b",
               err, o_valid, ack_tgl, exp_ack);
    end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) run_xfer(8'($urandom), 0, "b2b");
  endtask

  task automatic test_random();
    int gap;
    for (int i = 0; i < 40; i++) begin
      gap = int'($urandom_range(0, 2));
      for (int k = 0; k < gap; k++) begin
        checks++;
        if ({o_valid, err, ack_tgl} !== {1'b0, 1'b0, exp_ack}) begin
          errors++;
          $display("FAIL random_gap i=%0d: valid/err/ack=%b%b%b expected 00%b",
                   i, o_valid, err, ack_tgl, exp_ack);
        end
        step();
      end
      run_xfer(8'($urandom), int'($urandom_range(0, 4)), "random");
    end
  endtask
`else
  task automatic test_buffered();
    logic [DW-1:0] exp_d;
    step();
    o_ready = 1'b0;
    // Word 1: one slot stays free, so ack returns one cycle after capture.
    req_sync = ~req_sync; bus_d = 8'h01;
    repeat (S + 2) step();
    exp_ack = ~exp_ack;
    checks++;
    if ({ack_tgl, o_valid, o_data} !== {exp_ack, 1'b1, 8'h01}) begin
      errors++;
      $display("FAIL buf_w1: ack/valid/data=%b %b %h expected %b 1 01",
               ack_tgl, o_valid, o_data, exp_ack);
    end
    // Word 2 fills the FIFO: ack is held.
    req_sync = ~req_sync; bus_d = 8'h02;
    for (int k = 0; k < S + 7; k++) begin
      step();
      checks++;
      if ({ack_tgl, o_data} !== {exp_ack, 8'h01}) begin
        errors++;
        $display("FAIL buf_w2_held k=%0d: ack=%b data=%h expected %b 01",
                 k, ack_tgl, o_data, exp_ack);
      end
    end
    // Pop word 1; the held ack goes out in the following cycle.
    o_ready = 1'b1;
    step();
    o_ready = 1'b0;
    checks++;
    if ({ack_tgl, o_valid, o_data} !== {exp_ack, 1'b1, 8'h02}) begin
      errors++;
      $display("FAIL buf_pop1: ack/valid/data=%b %b %h expected %b 1 02",
               ack_tgl, o_valid, o_data, exp_ack);
    end
    step();
    exp_ack = ~exp_ack;
    checks++;
    if (ack_tgl !== exp_ack) begin
      errors++;
      $display("FAIL buf_release: ack=%b expected %b", ack_tgl, exp_ack);
    end
    // Word 3 fills the FIFO again.
    req_sync = ~req_sync; bus_d = 8'h03;
    repeat (S + 3) step();
    checks++;
    if ({ack_tgl, o_data} !== {exp_ack, 8'h02}) begin
      errors++;
      $display("FAIL buf_w3_held: ack=%b data=%h expected %b 02", ack_tgl, o_data, exp_ack);
    end
    // Drain: order must be preserved.
    o_ready = 1'b1;
    for (int k = 2; k <= 3; k++) begin
      exp_d = 8'(k);
      checks++;
      if ({o_valid, o_data} !== {1'b1, exp_d}) begin
        errors++;
        $display("FAIL buf_drain w%0d: valid=%b data=%h expected 1 %h", k, o_valid, o_data, exp_d);
      end
      step();
    end
    o_ready = 1'b0;
    exp_ack = ~exp_ack;
    checks++;
    if ({ack_tgl, o_valid} !== {exp_ack, 1'b0}) begin
      errors++;
      $display("FAIL buf_final: ack/valid=%b%b expected %b0", ack_tgl, o_valid, exp_ack);
    end
  endtask
`endif

  // Settle sweep: bus changes every cycle, so the captured word identifies
  // exactly which cycle was sampled.
  task automatic test_sweep();
    logic [DW-1:0] vals [8];
    logic old_par;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 8; k++) vals[k] = 8'($urandom);
      step();
      old_par = sw_par;
      sw_par  = ~sw_par;
      sw_req  = ~sw_req;
      for (int k = 0; k < 8; k++) begin
        sw_bus = vals[k];
        for (int g = 0; g < 4; g++) begin
          checks++;
          if ({sw_valid[g], sw_ack[g], sw_err[g]} !==
              {(k == g + 1), ((k >= g + 2) ? sw_par : old_par), 1'b0}) begin
            errors++;
            $display("FAIL sweep S=%0d k=%0d: valid/ack/err=%b%b%b expected %b%b0",
                     g, k, sw_valid[g], sw_ack[g], sw_err[g], (k == g + 1),
                     ((k >= g + 2) ? sw_par : old_par));
          end
          if (k == g + 1) begin
            checks++;
            if (sw_data[g] !== vals[g]) begin
              errors++;
              $display("FAIL sweep_data S=%0d: data=%h expected %h", g, sw_data[g], vals[g]);
            end
          end
        end
        step();
      end
    end
  endtask

  initial begin
    test_reset();
`ifndef XSYNC_BUS_RX_BUF_EN
    test_single();
    test_stall();
    test_violation();
    test_back_to_back();
    test_random();
`else
    test_buffered();
`endif
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
